// File: rtl/pci_target_burst_if.sv
// pci_target_burst_if: PCI control/handshake signals shared by an initiator and one burst target
interface pci_target_burst_if;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] CBE;
  logic       TRDY;
  logic       DEVSEL;
  logic       STOP;
  logic       busy;
  modport master (output FRAME, IRDY, CBE, input TRDY, DEVSEL, STOP, busy);
  modport slave  (input FRAME, IRDY, CBE, output TRDY, DEVSEL, STOP, busy);
endinterface

// File: rtl/pci_target_burst.sv
// pci_target_burst: PCI-style burst target with wait states, byte enables and wrap/disconnect at top of memory
module pci_target_burst #(
  parameter logic [31:0] BASE_ADDR = 32'h11111111,
  parameter int          AW        = 3,
  parameter logic [3:0]  CMD_READ  = 4'b0110,
  parameter logic [3:0]  CMD_WRITE = 4'b0111,
  parameter int          WR_WAIT   = 1,
  parameter int          RD_WAIT   = 2,
  parameter bit          WRAP      = 1'b0,
  parameter bit          BE_LOW    = 1'b0
) (
  input  logic              CLK,
  input  logic              reset,
  pci_target_burst_if.slave bif,
  inout  wire [31:0]        BUS
);
  localparam int DEPTH = 1 << AW;
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, XFER = 3'd2, DISC = 3'd3, TURN = 3'd4;
  logic [2:0]    state;
  logic          frame_q, rd, addr_ph, hit, done, top, last_wait;
  logic [AW-1:0] idx, idx_nx;
  logic [7:0]    wcnt;
  logic [3:0]    be;
  logic [31:0]   rd_reg, wdata;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   mem_nx [DEPTH];
  logic [31:0]   mem_rst [DEPTH];
  assign addr_ph   = state == IDLE && !bif.FRAME && frame_q;
  assign hit       = BUS[31:AW] == BASE_ADDR[31:AW] && (bif.CBE == CMD_READ || bif.CBE == CMD_WRITE);
  assign done      = state == XFER && !bif.IRDY;
  assign top       = idx == '1;
  assign idx_nx    = idx + 1'b1;
  assign last_wait = wcnt == (rd ? 8'(RD_WAIT - 1) : 8'(WR_WAIT - 1));
  assign be        = BE_LOW ? ~bif.CBE : bif.CBE;
  assign bif.TRDY   = state != XFER;
  assign bif.DEVSEL = !(state == XFER || state == DISC);
  assign bif.STOP   = state != DISC;
  assign bif.busy   = state != IDLE;
  // read data stays on the bus through DISC until the initiator lets go of FRAME
  assign BUS = (rd && (state == XFER || state == DISC)) ? rd_reg : 'z;
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign wdata[8*b +: 8] = be[b] ? BUS[8*b +: 8] : mem[idx][8*b +: 8];
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_init
    assign mem_rst[g] = 32'(g);
  end
  always_comb begin
    mem_nx = mem;
    if (done && !rd) mem_nx[idx] = wdata;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state   <= IDLE;
      frame_q <= 1'b1;
      rd      <= 1'b0;
      idx     <= '0;
      wcnt    <= '0;
      rd_reg  <= '0;
      mem     <= mem_rst;
    end else begin
      frame_q <= bif.FRAME;
      mem     <= mem_nx;
      case (state)
        IDLE: if (addr_ph && hit) begin
          state <= WAIT;
          idx   <= BUS[AW-1:0];
          rd    <= bif.CBE == CMD_READ;
          wcnt  <= '0;
        end
        WAIT:
          if (bif.FRAME && bif.IRDY) state <= IDLE;
          else if (last_wait) begin
            state  <= XFER;
            rd_reg <= mem[idx];
          end else wcnt <= wcnt + 8'd1;
        XFER: if (done) begin
          // prefetch the next word so back-to-back reads need no extra wait
          if (rd) rd_reg <= mem[idx_nx];
          if (WRAP || !top) idx <= idx_nx;
          state <= bif.FRAME ? TURN : (!WRAP && top) ? DISC : XFER;
        end
        DISC: if (bif.FRAME) state <= TURN;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pci_target_burst.sv
// tb_pci_target_burst: vector table, hand sequences and random bursts against a word-level memory model
module tb_pci_target_burst;
  localparam logic [3:0] RD = 4'b0110, WR = 4'b0111;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        frame = 1'b1, irdy = 1'b1, tb_en = 1'b0;
  logic [3:0]  cbe = 4'h0;
  logic [31:0] tb_bus = '0;
  wire  [31:0] bus;
  assign bus = tb_en ? tb_bus : 'z;
  pci_target_burst_if i0 (), i1 ();
  assign i0.FRAME = frame;
  assign i0.IRDY  = irdy;
  assign i0.CBE   = cbe;
  assign i1.FRAME = frame;
  assign i1.IRDY  = irdy;
  assign i1.CBE   = cbe;
  pci_target_burst u0 (.CLK(clk), .reset(rst), .bif(i0.slave), .BUS(bus));
  pci_target_burst #(.BASE_ADDR(32'h44444440), .WRAP(1'b1)) u1 (.CLK(clk), .reset(rst), .bif(i1.slave), .BUS(bus));

  int total = 0, bad = 0;
  logic [31:0] m [2][8];

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [3:0]  cmd;
    int          n;
    logic [3:0]  be;
    logic [31:0] d;
    int          lat;
    bit          stp;
    int          served;
  } vec_t;
  vec_t v [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) for (int k = 0; k < 8; k++) m[i][k] = 32'(k);
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_trdy0"}, i0.TRDY, 1'b1);
    chk({nm, "_devsel0"}, i0.DEVSEL, 1'b1);
    chk({nm, "_stop0"}, i0.STOP, 1'b1);
    chk({nm, "_busy0"}, i0.busy, 1'b0);
    chk({nm, "_busy1"}, i1.busy, 1'b0);
  endtask

  task automatic burst(input int inst, input logic [31:0] addr, input logic [3:0] cmd, input int n,
                       input logic [3:0] be, input logic [31:0] d, input bit waits,
                       output int lat, output bit stp, output int served);
    bit rd;
    int k, w, idx;
    logic tr, st;
    rd = cmd == RD;
    k = 0;
    lat = -1;
    stp = 1'b0;
    idx = int'(addr[2:0]);
    @(negedge clk);
    frame = 1'b0; irdy = 1'b1; cbe = cmd; tb_bus = addr; tb_en = 1'b1;
    @(negedge clk);
    cbe = be; tb_en = !rd;
    w = waits ? int'($urandom_range(2)) : 0;
    for (int c = 0; c < 80 && k < n; c++) begin
      tr = inst != 0 ? i1.TRDY : i0.TRDY;
      st = inst != 0 ? i1.STOP : i0.STOP;
      if (c == 0) chk("busy_wait", inst != 0 ? i1.busy : i0.busy, 1'b1);
      if (!tr && lat < 0) lat = c;
      if (!st) begin
        stp = 1'b1;
        break;
      end
      if (w > 0) begin
        irdy = 1'b1; frame = 1'b0; w--;
      end else begin
        irdy = 1'b0; frame = k == n - 1; tb_bus = d + 32'(k);
        if (!tr) begin
          if (rd) chk("rdata", bus, m[inst][(idx + k) % 8]);
          else m[inst][(idx + k) % 8] = merge(m[inst][(idx + k) % 8], d + 32'(k), be);
          k++;
          w = waits ? int'($urandom_range(2)) : 0;
        end
      end
      @(negedge clk);
    end
    served = k;
    if (k < n && !stp) chk("timeout", 32'(k), 32'(n));
    frame = 1'b1; irdy = 1'b1; tb_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_idle", inst != 0 ? i1.busy : i0.busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int lat, served, inst, idx, n, e;
    bit stp, rdc, sexp;
    logic [3:0] be;
    model_reset();
    v[0] = '{0, 32'h11111110, RD, 8, 4'hF, 32'h0,        2, 1'b0, 8};
    v[1] = '{0, 32'h11111110, WR, 4, 4'hF, 32'h10203040, 1, 1'b0, 4};
    v[2] = '{0, 32'h11111112, RD, 3, 4'hF, 32'h0,        2, 1'b0, 3};
    v[3] = '{0, 32'h11111115, WR, 1, 4'h5, 32'hAABBCCDD, 1, 1'b0, 1};
    v[4] = '{0, 32'h11111115, RD, 1, 4'hF, 32'h0,        2, 1'b0, 1};
    v[5] = '{0, 32'h11111116, WR, 4, 4'hF, 32'hCAFE0000, 1, 1'b1, 2};
    v[6] = '{0, 32'h11111116, RD, 3, 4'hF, 32'h0,        2, 1'b1, 2};
    v[7] = '{1, 32'h44444447, RD, 3, 4'hF, 32'h0,        2, 1'b0, 3};
    v[8] = '{1, 32'h44444446, WR, 5, 4'hA, 32'h12345678, 1, 1'b0, 5};
    v[9] = '{1, 32'h44444440, RD, 8, 4'hF, 32'h0,        2, 1'b0, 8};
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      burst(v[i].inst, v[i].addr, v[i].cmd, v[i].n, v[i].be, v[i].d, i[0], lat, stp, served);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_stop", i), 32'(stp), 32'(v[i].stp));
      chk($sformatf("v%0d_served", i), 32'(served), 32'(v[i].served));
    end
    // address outside both windows, and a non-memory command inside one: nobody responds
    @(negedge clk);
    frame = 1'b0; cbe = RD; tb_bus = 32'h33333333; tb_en = 1'b1;
    @(negedge clk);
    irdy = 1'b0; tb_bus = 32'h0F0F0F0F; cbe = 4'hF;
    repeat (4) begin
      @(negedge clk);
      idle_chk("miss");
      chk("miss_bus", bus, 32'h0F0F0F0F);
    end
    frame = 1'b1; irdy = 1'b1;
    @(negedge clk);
    frame = 1'b0; cbe = 4'b0010; tb_bus = 32'h11111110;
    repeat (3) @(negedge clk);
    idle_chk("iocmd");
    frame = 1'b1; tb_en = 1'b0;
    // master abort while the target is still counting wait states
    @(negedge clk);
    frame = 1'b0; cbe = RD; tb_bus = 32'h11111113; tb_en = 1'b1;
    @(negedge clk);
    chk("abort_busy", i0.busy, 1'b1);
    frame = 1'b1; irdy = 1'b1; tb_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      idle_chk("abort");
    end
    // reset asserted in the middle of a write data phase
    frame = 1'b0; cbe = WR; tb_bus = 32'h11111110; tb_en = 1'b1;
    @(negedge clk);
    cbe = 4'hF; tb_bus = 32'hDEADBEEF; irdy = 1'b0;
    @(negedge clk);
    chk("mid_trdy", i0.TRDY, 1'b0);
    rst = 1'b1;
    #1;
    idle_chk("midrst");
    frame = 1'b1; irdy = 1'b1; tb_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    burst(0, 32'h11111110, RD, 8, 4'hF, 32'h0, 1'b0, lat, stp, served);
    chk("rst_served", 32'(served), 32'd8);
    // random bursts against the model
    for (int r = 0; r < 30; r++) begin
      inst = int'($urandom_range(1));
      rdc  = 1'($urandom_range(1));
      idx  = int'($urandom_range(7));
      n    = int'($urandom_range(1, 10));
      be   = 4'($urandom);
      e    = 8 - idx;
      sexp = inst == 0 && n > e;
      burst(inst, (inst != 0 ? 32'h44444440 : 32'h11111110) | 32'(idx), rdc ? RD : WR, n, be,
            $urandom, 1'b1, lat, stp, served);
      chk($sformatf("r%0d_lat", r), 32'(lat), rdc ? 32'd2 : 32'd1);
      chk($sformatf("r%0d_stop", r), 32'(stp), 32'(sexp));
      chk($sformatf("r%0d_served", r), 32'(served), 32'(sexp ? e : n));
    end
    for (int i = 0; i < 2; i++) begin
      burst(i, i != 0 ? 32'h44444440 : 32'h11111110, RD, 8, 4'hF, 32'h0, 1'b0, lat, stp, served);
      chk($sformatf("final%0d_served", i), 32'(served), 32'd8);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
